// File: rtl/data_mem_pkg.sv
// Shared encodings and lane-math helpers for the byte-addressed data memory LSU.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Mask is sized for the widest (8-lane) word; narrower callers truncate.
  function automatic logic [7:0] byte_enable(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
    logic [2:0] mask;
    mask = 3'(size_bytes(size) - 4'd1);
    return |(offset & mask);
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Combinational lane steering: shifts store data into byte lanes and extracts/extends load data.
module data_mem_align
  import data_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int OFF_W = $clog2(WIDTH / 8)
) (
  input  logic [1:0]       size,
  input  logic             uns,
  input  logic [OFF_W-1:0] offset,
  input  logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] rword,
  output logic [WIDTH-1:0] wlanes,
  output logic [WIDTH-1:0] rd_ext
);

  logic [OFF_W+2:0] shamt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word_ext;

  assign shamt   = {offset, 3'b000};
  assign wlanes  = wd << shamt;
  assign shifted = rword >> shamt;

  // A 32-bit word only needs extending when the datapath is wider than it.
  if (WIDTH > 32) begin : g_word_ext
    assign word_ext = {{(WIDTH-32){shifted[31] & ~uns}}, shifted[31:0]};
  end else begin : g_word_full
    assign word_ext = shifted;
  end

  always_comb begin
    rd_ext = '0;
    case (size)
      SZ_BYTE: rd_ext = {{(WIDTH-8){shifted[7] & ~uns}}, shifted[7:0]};
      SZ_HALF: rd_ext = {{(WIDTH-16){shifted[15] & ~uns}}, shifted[15:0]};
      SZ_WORD: rd_ext = word_ext;
      default: rd_ext = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// MEM-stage load/store unit: byte-addressed RAM with a post-reset clear sweep and a 1-cycle registered response.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 WE,
  input  logic [1:0]           SIZE,
  input  logic                 UNSIGNED,
  input  logic [ADDR_W-1:0]    A,
  input  logic [WIDTH-1:0]     WD,
  output logic [WIDTH-1:0]     RD,
  output logic                 RD_VALID,
  output logic                 ERR,
  output logic                 BUSY,
  output logic [WIDTH/2-1:0]   test_value
);

  localparam int LANES  = WIDTH / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  ram [DEPTH];
  state_t            state;
  state_t            next_state;
  logic [RAM_AW-1:0] clr_idx;

  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  idx;
  logic [RAM_AW-1:0] widx;
  logic              out_of_range;
  logic              bad_size;
  logic              err;
  logic              accept;
  logic [LANES-1:0]  be;
  logic [WIDTH-1:0]  rword;
  logic [WIDTH-1:0]  wlanes;
  logic [WIDTH-1:0]  rd_ext;

  assign offset = A[OFF_W-1:0];
  assign idx    = A[ADDR_W-1:OFF_W];
  assign widx   = idx[RAM_AW-1:0];

  // Range check sees every index bit, so stray high address bits are errors rather than aliases.
  assign out_of_range = 64'(idx) >= 64'(DEPTH);
  assign bad_size     = (SIZE == SZ_DWORD) && (WIDTH == 32);
  assign err          = misaligned(SIZE, 3'(offset)) | out_of_range | bad_size;
  assign be           = LANES'(byte_enable(SIZE, 3'(offset)));
  assign accept       = REQ_VALID & REQ_READY & ~RST;
  assign rword        = ram[widx];

  data_mem_align #(.WIDTH(WIDTH)) u_align (
    .size   (SIZE),
    .uns    (UNSIGNED),
    .offset (offset),
    .wd     (WD),
    .rword  (rword),
    .wlanes (wlanes),
    .rd_ext (rd_ext)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= next_state;
      if (state == ST_CLEAR) clr_idx <= clr_idx + RAM_AW'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_CLEAR: if (clr_idx == RAM_AW'(DEPTH - 1)) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY      = (state == ST_CLEAR);
    REQ_READY = (state == ST_IDLE);
  end

  // RAM: clear sweep has priority; stores touch only enabled lanes.
  always_ff @(posedge CLK) begin
    if (state == ST_CLEAR) begin
      ram[clr_idx] <= '0;
    end else if (accept && WE && !err) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) ram[widx][i*8 +: 8] <= wlanes[i*8 +: 8];
      end
    end
  end

  // Response stage: RD/ERR hold between strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RD       <= '0;
      RD_VALID <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      RD_VALID <= accept;
      if (accept) begin
        ERR <= err;
        RD  <= (WE || err) ? '0 : rd_ext;
      end
    end
  end

  assign test_value = ram[0][WIDTH/2-1:0];

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu (WIDTH=32, DEPTH=256).
module tb_data_mem_lsu;

  logic        CLK;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        WE;
  logic [1:0]  SIZE;
  logic        UNSIGNED;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        RD_VALID;
  logic        ERR;
  logic        BUSY;
  logic [15:0] test_value;

  int tests = 0;
  int fails = 0;

  data_mem_lsu #(.WIDTH(32), .DEPTH(256), .ADDR_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .WE         (WE),
    .SIZE       (SIZE),
    .UNSIGNED   (UNSIGNED),
    .A          (A),
    .WD         (WD),
    .RD         (RD),
    .RD_VALID   (RD_VALID),
    .ERR        (ERR),
    .BUSY       (BUSY),
    .test_value (test_value)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request, accepted at the next edge; response is sampled 1 time unit later.
  task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd);
    WE = we; SIZE = sz; UNSIGNED = uns; A = a; WD = wd;
    REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] exp);
    req(1'b0, sz, uns, a, 32'h0);
    chk({tag, "_vld"}, {31'b0, RD_VALID}, 32'd1);
    chk({tag, "_rd"}, RD, exp);
    chk({tag, "_err"}, {31'b0, ERR}, 32'd0);
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    req(1'b1, sz, 1'b0, a, wd);
    chk({tag, "_vld"}, {31'b0, RD_VALID}, 32'd1);
    chk({tag, "_rd"}, RD, 32'h0);
    chk({tag, "_err"}, {31'b0, ERR}, 32'd0);
  endtask

  task automatic bad(input string tag, input logic we, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    req(we, sz, 1'b0, a, wd);
    chk({tag, "_vld"}, {31'b0, RD_VALID}, 32'd1);
    chk({tag, "_rd"}, RD, 32'h0);
    chk({tag, "_err"}, {31'b0, ERR}, 32'd1);
  endtask

  // Counts BUSY cycles with REQ_VALID held high; nothing may be accepted meanwhile.
  task automatic sweep(input string tag);
    int cnt;
    logic rdv_seen;
    logic rdy_bad;
    cnt = 0; rdv_seen = 1'b0; rdy_bad = 1'b0;
    WE = 1'b0; SIZE = 2'b10; A = 32'h0; REQ_VALID = 1'b1;
    while (BUSY === 1'b1 && cnt < 400) begin
      if (REQ_READY !== 1'b0) rdy_bad = 1'b1;
      @(posedge CLK); #1;
      cnt++;
      if (RD_VALID !== 1'b0) rdv_seen = 1'b1;
    end
    REQ_VALID = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'd256);
    chk({tag, "_no_rd_valid"}, {31'b0, rdv_seen}, 32'd0);
    chk({tag, "_ready_low"}, {31'b0, rdy_bad}, 32'd0);
    chk({tag, "_ready_after"}, {31'b0, REQ_READY}, 32'd1);
  endtask

  initial begin
    int nz;
    RST = 1'b1; REQ_VALID = 1'b0; WE = 1'b0; SIZE = 2'b00;
    UNSIGNED = 1'b0; A = 32'h0; WD = 32'h0;

    // Reset and first clear sweep
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rd_valid", {31'b0, RD_VALID}, 32'd0);
    chk("rst_rd", RD, 32'h0);
    chk("rst_err", {31'b0, ERR}, 32'd0);
    chk("rst_busy", {31'b0, BUSY}, 32'd1);
    RST = 1'b0;
    sweep("clear1");

    nz = 0;
    for (int i = 0; i < 256; i++) begin
      req(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
      if (RD_VALID !== 1'b1 || RD !== 32'h0 || ERR !== 1'b0) nz++;
    end
    chk("clear_all_zero", 32'(nz), 32'd0);

    // Byte store and loads
    store("st_b5", 2'b00, 32'h5, 32'h0000_00AB);
    load("ld_w4", 2'b10, 1'b0, 32'h4, 32'h0000_AB00);
    load("ld_sb5", 2'b00, 1'b0, 32'h5, 32'hFFFF_FFAB);
    load("ld_ub5", 2'b00, 1'b1, 32'h5, 32'h0000_00AB);
    chk("tv_after_byte", {16'h0, test_value}, 32'h0);

    // Output hold while idle
    @(posedge CLK); #1;
    chk("hold_vld_low", {31'b0, RD_VALID}, 32'd0);
    chk("hold_rd", RD, 32'h0000_00AB);

    // Word then half
    store("st_w0", 2'b10, 32'h0, 32'h1234_5678);
    chk("tv_word", {16'h0, test_value}, 32'h5678);
    store("st_h2", 2'b01, 32'h2, 32'h0000_BEEF);
    load("ld_w0", 2'b10, 1'b0, 32'h0, 32'hBEEF_5678);
    chk("tv_half", {16'h0, test_value}, 32'h5678);
    load("ld_sh2", 2'b01, 1'b0, 32'h2, 32'hFFFF_BEEF);
    load("ld_uh2", 2'b01, 1'b1, 32'h2, 32'h0000_BEEF);
    load("ld_uw0", 2'b10, 1'b1, 32'h0, 32'hBEEF_5678);

    // Error cases, with stores that must not land
    bad("err_h1", 1'b1, 2'b01, 32'h1, 32'h0000_FFFF);
    bad("err_w2", 1'b1, 2'b10, 32'h2, 32'hFFFF_FFFF);
    bad("err_w400", 1'b1, 2'b10, 32'h400, 32'hDEAD_DEAD);
    bad("err_ld400", 1'b0, 2'b10, 32'h400, 32'h0);
    bad("err_dword", 1'b1, 2'b11, 32'h0, 32'hFFFF_FFFF);
    bad("err_hibit", 1'b0, 2'b10, 32'h8000_0000, 32'h0);
    @(posedge CLK); #1;
    chk("hold_err", {31'b0, ERR}, 32'd1);
    load("ld_w0_intact", 2'b10, 1'b0, 32'h0, 32'hBEEF_5678);

    // Back-to-back store then load
    WE = 1'b1; SIZE = 2'b10; UNSIGNED = 1'b0; A = 32'h8; WD = 32'hCAFE_F00D;
    REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    chk("b2b_st_vld", {31'b0, RD_VALID}, 32'd1);
    chk("b2b_st_rd", RD, 32'h0);
    WE = 1'b0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    chk("b2b_ld_vld", {31'b0, RD_VALID}, 32'd1);
    chk("b2b_ld_rd", RD, 32'hCAFE_F00D);
    @(posedge CLK); #1;
    chk("b2b_vld_drop", {31'b0, RD_VALID}, 32'd0);

    // Reset lands on the edge where the load response would be replaced
    WE = 1'b0; SIZE = 2'b10; A = 32'h8; REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    chk("mid_ld_vld", {31'b0, RD_VALID}, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("mid_rst_vld", {31'b0, RD_VALID}, 32'd0);
    chk("mid_rst_busy", {31'b0, BUSY}, 32'd1);
    RST = 1'b0;
    sweep("clear2");
    load("ld_w8_cleared", 2'b10, 1'b0, 32'h8, 32'h0);
    chk("tv_cleared", {16'h0, test_value}, 32'h0);

    // Reset partway through a sweep restarts it from the beginning
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (100) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    sweep("clear3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised successor to the single-word data memory.
- Byte-addressed load/store memory with byte, half, word and (WIDTH=64) dword accesses, sign or zero extension, and misalignment/range error detection.
- Valid/ready request handshake with a registered, 1-cycle read response.
- A hardware clear sweep after reset replaces the single-cycle whole-array clear.
- Sits in the MEM stage of the pipeline, driven by the ALU address and the store data.

Parameters:
- WIDTH, 32: word width in bits; legal values 32 or 64.
- DEPTH, 256: number of words.
- ADDR_W, 32: byte-address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request.
- WE  in  1  1 = store, 0 = load.
- SIZE  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when WIDTH=64).
- UNSIGNED  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- A  in  ADDR_W  byte address.
- WD  in  WIDTH  store data, right-aligned.
- RD  out  WIDTH  load data, extended to WIDTH.
- RD_VALID  out  1  response strobe, one cycle per accepted request.
- ERR  out  1  error flag, qualified by RD_VALID.
- BUSY  out  1  clear sweep in progress.
- test_value  out  WIDTH/2  RAM[0][WIDTH/2-1:0], combinational.

Behaviour:
- Reset: while RST=1 at a CLK edge:
  - state<=CLEAR, clear index<=0.
  - RD<=0, RD_VALID<=0, ERR<=0.
  - Any pending response is dropped.
  - RST asserted mid-sweep restarts the sweep at index 0.
- CLEAR state:
  - Each cycle RAM[idx]<=0 and idx increments.
  - BUSY=1, REQ_READY=0.
  - REQ_VALID is ignored; nothing is accepted or queued.
  - After idx=DEPTH-1 is written, the next state is IDLE. The sweep takes exactly DEPTH cycles.
- IDLE state:
  - BUSY=0, REQ_READY=1.
  - Accept = REQ_VALID & REQ_READY. One request can be accepted per cycle, back-to-back.
- Addressing:
  - Word index = A >> log2(WIDTH/8).
  - Lane offset = low log2(WIDTH/8) bits of A.
  - Lanes are little-endian.
- Error conditions (any one sets ERR):
  - A is not a multiple of the access size in bytes.
  - Word index >= DEPTH.
  - SIZE=11 with WIDTH=32.
- Error handling: no RAM write, RD=0, ERR=1 with RD_VALID.
- Store: on the accept edge, only the selected byte lanes are written, using WD's low bytes; other bytes are unchanged. The response is RD_VALID=1, RD=0, ERR=0.
- Load:
  - The lane is extracted from the current RAM contents at the accept edge and extended per UNSIGNED.
  - A word load on WIDTH=32, or a dword load, ignores UNSIGNED.
- Latency: the response for the request accepted at edge N is visible after edge N; RD_VALID is high for exactly that one cycle, then returns low unless another request is accepted.
- Read-after-write: a load accepted at edge N+1 returns data written by a store accepted at edge N.
- Output hold: RD and ERR hold their last values when RD_VALID=0.
- test_value: reflects RAM[0] combinationally, including bytes being written and the clear sweep.
- Arithmetic: index comparison uses the full index width with no truncation before the range check; A bits above the index are therefore included in the check.

Decomposition:
- data_mem_pkg:
  - SIZE encodings as localparams.
  - Function size_bytes(SIZE).
  - Function byte_enable(SIZE, offset) returning a WIDTH/8 mask.
  - Function misaligned(SIZE, offset).
- Sub-module data_mem_align (combinational):
  - Store path: replicate/shift WD into lanes.
  - Load path: shift the read word down and sign/zero-extend.
- The top module holds the FSM, clear counter, RAM array and response registers.

Test Plan:
- Reset/clear: RST=1 for 2 cycles, then 0.
  - BUSY=1 and REQ_READY=0 for exactly 256 cycles.
  - REQ_VALID during the sweep produces no RD_VALID.
  - Every word then reads 0.
- Byte store/load: store 0xAB at A=0x5 (SIZE=00).
  - Word load at A=0x4 returns 0x0000AB00.
  - Signed byte load at A=0x5 returns 0xFFFFFFAB; unsigned returns 0x000000AB.
  - test_value is unaffected (0x0000).
- Half and word: store word 0x12345678 at A=0x0, then store half 0xBEEF at A=0x2.
  - Word load returns 0xBEEF5678; test_value=0x5678.
  - Signed half load at A=0x2 returns 0xFFFFBEEF.
- Errors:
  - Half at A=0x1, word at A=0x2, and word at A=0x400 with DEPTH=256 each give RD_VALID=1, ERR=1, RD=0.
  - The targeted word is unchanged.
- Back-to-back: store word 0xCAFEF00D at A=0x8, then a load at A=0x8 on the next cycle.
  - The load returns 0xCAFEF00D.
  - RD_VALID is high on 2 consecutive cycles.
- Reset mid-operation: accept a load, then assert RST in the same cycle the response would appear.
  - The response after the RST edge is RD_VALID=0.
  - The clear sweep restarts from index 0 and takes a full DEPTH cycles.
